// File: rtl/seg_pkg.sv
// Shared types and constants for the four-digit seven-segment display path.
// Segment bytes are active-low with bit 7 = segment a down to bit 0 = decimal point.
package seg_pkg;

    typedef enum logic {S_BLANK, S_DRIVE} scan_state_t;

    typedef logic [1:0] digit_idx_t;
    typedef logic [7:0] seg_t;
    typedef seg_t [3:0] seg_frame_t;

    localparam int unsigned NUM_DIGITS = 4;
    localparam seg_t SEG_BLANK = 8'hFF;

    // Decimal digit glyphs 0..9 as used by the game FSMs.
    localparam seg_t SEG_DIGITS [10] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
        8'h49, 8'h41, 8'h1F, 8'h01, 8'h09
    };

    function automatic seg_t seg_of_digit(input logic [3:0] d);
        seg_t r;
        r = SEG_BLANK;
        if (d < 4'd10) r = SEG_DIGITS[d];
        return r;
    endfunction

endpackage

// File: rtl/seg_display_scheduler_dwell_counter.sv
// Loadable down-counter; tc_c flags the last cycle of the current interval.
module dwell_counter #(
    parameter int unsigned     W         = 4,
    parameter logic [W-1:0]    RST_VALUE = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         tc_c
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RST_VALUE;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign tc_c = (count_q == '0);

endmodule

// File: rtl/seg_display_scheduler.sv
// Time-multiplexed scan of a four-digit seven-segment display with blanking
// gaps and a double-buffered frame that only commits on frame boundaries.
module seg_display_scheduler
    import seg_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 4096,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] digitA,
    input  logic [7:0] digitB,
    input  logic [7:0] digitC,
    input  logic [7:0] digitD,
    output logic [7:0] sevenSegmentDisplay,
    output logic       displayA,
    output logic       displayB,
    output logic       displayC,
    output logic       displayD,
    output logic       update_pending,
    output logic       frame_done
);

    localparam int unsigned MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

    scan_state_t      state_q, nxt_state;
    digit_idx_t       idx_q, nxt_idx;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic             tc_c;
    logic             boundary;

    seg_frame_t       active_q, pending_q, din;
    seg_t             seg_d, seg_q;
    logic [3:0]       disp_n_d, disp_n_q;
    logic             frame_done_d, frame_done_q, pending_flag_q;

    assign din = {digitD, digitC, digitB, digitA};

    dwell_counter #(
        .W         (CNT_W),
        .RST_VALUE (BLANK_LOAD)
    ) u_dwell (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (cnt_value),
        .tc_c       (tc_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BLANK;
            idx_q   <= '0;
        end else begin
            state_q <= nxt_state;
            idx_q   <= nxt_idx;
        end
    end

    // Next scan position; disabling parks the scan where reset leaves it.
    always_comb begin
        nxt_state    = state_q;
        nxt_idx      = idx_q;
        cnt_load     = 1'b0;
        cnt_value    = '0;
        boundary     = 1'b0;
        seg_d        = SEG_BLANK;
        disp_n_d     = 4'hF;
        frame_done_d = 1'b0;

        if (!en) begin
            nxt_state = S_BLANK;
            nxt_idx   = '0;
            cnt_load  = 1'b1;
            cnt_value = BLANK_LOAD;
        end else if (tc_c) begin
            cnt_load = 1'b1;
            if (state_q == S_BLANK) begin
                nxt_state = S_DRIVE;
                cnt_value = DWELL_LOAD;
            end else begin
                nxt_state = S_BLANK;
                nxt_idx   = digit_idx_t'(idx_q + 2'd1);
                cnt_value = BLANK_LOAD;
                boundary  = (idx_q == digit_idx_t'(NUM_DIGITS - 1));
            end
        end

        // Active buffer never changes on an edge that enters S_DRIVE.
        if (nxt_state == S_DRIVE) begin
            seg_d    = active_q[nxt_idx];
            disp_n_d = ~(4'b0001 << nxt_idx);
        end
        frame_done_d = boundary;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q        <= SEG_BLANK;
            disp_n_q     <= 4'hF;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            disp_n_q     <= disp_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    // A load landing on the boundary bypasses the pending buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q       <= {NUM_DIGITS{SEG_BLANK}};
            pending_q      <= {NUM_DIGITS{SEG_BLANK}};
            pending_flag_q <= 1'b0;
        end else if (load) begin
            if (boundary) begin
                active_q       <= din;
                pending_flag_q <= 1'b0;
            end else begin
                pending_q      <= din;
                pending_flag_q <= 1'b1;
            end
        end else if (boundary && pending_flag_q) begin
            active_q       <= pending_q;
            pending_flag_q <= 1'b0;
        end
    end

    assign sevenSegmentDisplay = seg_q;
    assign displayA            = disp_n_q[0];
    assign displayB            = disp_n_q[1];
    assign displayC            = disp_n_q[2];
    assign displayD            = disp_n_q[3];
    assign update_pending      = pending_flag_q;
    assign frame_done          = frame_done_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed plus randomized bench for seg_display_scheduler against a
// frame-position reference model (position within frame -> expected outputs).
module tb_seg_display_scheduler;

    localparam int unsigned DW    = 4;
    localparam int unsigned BL    = 2;
    localparam int unsigned SLOT  = DW + BL;
    localparam int unsigned FRAME = 4 * SLOT;

    logic       clk = 1'b0;
    logic       rst, en, load;
    logic [7:0] digitA, digitB, digitC, digitD;
    logic [7:0] sevenSegmentDisplay;
    logic       displayA, displayB, displayC, displayD;
    logic       update_pending, frame_done;

    seg_display_scheduler #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .en                  (en),
        .load                (load),
        .digitA              (digitA),
        .digitB              (digitB),
        .digitC              (digitC),
        .digitD              (digitD),
        .sevenSegmentDisplay (sevenSegmentDisplay),
        .displayA            (displayA),
        .displayB            (displayB),
        .displayC            (displayC),
        .displayD            (displayD),
        .update_pending      (update_pending),
        .frame_done          (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [7:0] m_act [4];
    logic [7:0] m_pend [4];
    logic       m_flag, m_fd;
    int         m_pos;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks = checks + 1;
        assert (got === exp) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_pos  = 0;
        m_fd   = 1'b0;
        m_flag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_act[i]  = 8'hFF;
            m_pend[i] = 8'hFF;
        end
    endtask

    // One clock edge of the reference: frame position advances, loads apply.
    task automatic model_edge();
        logic bnd;
        logic [7:0] d [4];
        d[0] = digitA; d[1] = digitB; d[2] = digitC; d[3] = digitD;
        bnd  = en && (m_pos == FRAME - 1);
        m_pos = en ? (m_pos + 1) % FRAME : 0;
        m_fd  = bnd;
        if (load) begin
            for (int i = 0; i < 4; i++) begin
                if (bnd) m_act[i] = d[i];
                else     m_pend[i] = d[i];
            end
            m_flag = !bnd;
        end else if (bnd && m_flag) begin
            for (int i = 0; i < 4; i++) m_act[i] = m_pend[i];
            m_flag = 1'b0;
        end
    endtask

    task automatic check_outputs();
        int         slot_i;
        logic       drv;
        logic [7:0] e_seg;
        logic [3:0] e_dn, dn;
        slot_i = m_pos / SLOT;
        drv    = (m_pos % SLOT) >= BL;
        e_seg  = drv ? m_act[slot_i] : 8'hFF;
        e_dn   = drv ? ~(4'b0001 << slot_i) : 4'hF;
        dn     = {displayD, displayC, displayB, displayA};
        chk("segments", sevenSegmentDisplay, e_seg);
        chk("enables", 8'(dn), 8'(e_dn));
        chk("update_pending", 8'(update_pending), 8'(m_flag));
        chk("frame_done", 8'(frame_done), 8'(m_fd));
        chk("one_enable_max", 8'($countones(~dn) <= 1), 8'd1);
        if (dn == 4'hF) chk("dark_segments", sevenSegmentDisplay, 8'hFF);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic tick_to(input int p);
        for (int k = 0; k < 4 * FRAME && m_pos != p; k++) tick();
        if (m_pos != p) begin
            checks = checks + 1;
            $error("FAIL tick_to observed=%0d expected=%0d", m_pos, p);
        end
    endtask

    task automatic do_load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        digitA = a; digitB = b; digitC = c; digitD = d;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b0;
        digitA = 8'h00; digitB = 8'h00; digitC = 8'h00; digitD = 8'h00;
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Scenario 1: idle scan, two full frames
        for (int i = 0; i < 2 * FRAME; i++) tick();

        // Scenario 2: load mid digit B
        tick_to(9);
        do_load(8'h03, 8'h9F, 8'h25, 8'h0D);
        tick_to(FRAME - 1);
        tick_to(8);
        chk("scn2_digitB", sevenSegmentDisplay, 8'h9F);

        // Scenario 3: two loads in one frame, last wins
        tick_to(2);
        do_load(8'h03, 8'h99, 8'h25, 8'h0D);
        tick_to(14);
        do_load(8'h03, 8'h49, 8'h25, 8'h0D);
        tick_to(9);
        chk("scn3_digitB", sevenSegmentDisplay, 8'h49);

        // Scenario 4: load on the boundary edge
        tick_to(FRAME - 1);
        do_load(8'h41, 8'h1F, 8'h01, 8'h09);
        chk("scn4_no_pending", 8'(update_pending), 8'd0);
        tick_to(2);
        chk("scn4_digitA", sevenSegmentDisplay, 8'h41);

        // Scenario 5: en low during digit C, load while disabled
        tick_to(14);
        en = 1'b0;
        tick();
        do_load(8'h41, 8'h1F, 8'h01, 8'h01);
        tick(); tick(); tick();
        en = 1'b1;
        tick_to(20);
        chk("scn5_old_D", sevenSegmentDisplay, 8'h09);
        tick_to(FRAME - 1);
        tick_to(20);
        chk("scn5_new_D", sevenSegmentDisplay, 8'h01);

        // Scenario 6: asynchronous reset during digit B
        tick_to(9);
        #1 rst = 1'b1;
        #1;
        chk("async_seg", sevenSegmentDisplay, 8'hFF);
        chk("async_en", 8'({displayD, displayC, displayB, displayA}), 8'h0F);
        model_reset();
        #1 rst = 1'b0;
        for (int i = 0; i < FRAME + 4; i++) tick();

        // Randomized loads and enable drops
        for (int i = 0; i < 400; i++) begin
            if (!en) en = ($urandom_range(0, 2) == 0);
            else     en = ($urandom_range(0, 59) != 0);
            digitA = 8'($urandom); digitB = 8'($urandom);
            digitC = 8'($urandom); digitD = 8'($urandom);
            load = ($urandom_range(0, 7) == 0);
            tick();
            load = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
